// File: rtl/ring_router_bidir.sv
// Bidirectional ring stop: CW/CCW link ports plus a local PE port, per-input FIFOs, registered outputs.
// Define RING_ROUTER_STATS_EN to add the stat_eject/stat_stall counters.
module ring_router_bidir #(
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 2,
    parameter int HOP_LSB = 48,
    parameter int HOP_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
`ifdef RING_ROUTER_STATS_EN
    output logic [15:0]       stat_eject,
    output logic [15:0]       stat_stall,
`endif
    input  logic              cwsi,
    output logic              cwri,
    input  logic [DATA_W-1:0] cwdi,
    output logic              cwso,
    input  logic              cwro,
    output logic [DATA_W-1:0] cwdo,
    input  logic              ccwsi,
    output logic              ccwri,
    input  logic [DATA_W-1:0] ccwdi,
    output logic              ccwso,
    input  logic              ccwro,
    output logic [DATA_W-1:0] ccwdo,
    input  logic              pesi,
    output logic              peri,
    input  logic [DATA_W-1:0] pedi,
    output logic              peso,
    input  logic              pero,
    output logic [DATA_W-1:0] pedo
);
    localparam int AW = $clog2(DEPTH);

    // index 0 = CW, 1 = CCW, 2 = PE for both the input FIFOs and the output registers
    logic [DATA_W-1:0] mem_q [3][DEPTH];
    logic [DATA_W-1:0] mem_d [3][DEPTH];
    logic [AW-1:0]     wr_ptr_q [3];
    logic [AW-1:0]     wr_ptr_d [3];
    logic [AW-1:0]     rd_ptr_q [3];
    logic [AW-1:0]     rd_ptr_d [3];
    logic [AW:0]       cnt_q [3];
    logic [AW:0]       cnt_d [3];

    logic [2:0]        out_v_q, out_v_d;
    logic [DATA_W-1:0] out_dat_q [3];
    logic [DATA_W-1:0] out_dat_d [3];
    logic [1:0]        link_prio_q, link_prio_d;   // 1 = PE inject wins a tie on that link
    logic [1:0]        pe_ptr_q, pe_ptr_d;

    logic [2:0]        in_v, out_rdy, full, push, pop, head_v, ld, pe_req;
    logic [DATA_W-1:0] in_dat [3];
    logic [DATA_W-1:0] head [3];
    logic [1:0]        fwd, pe_inj;
    logic              found;
    int                idx;

    function automatic logic [DATA_W-1:0] dec_hop(input logic [DATA_W-1:0] f);
        logic [DATA_W-1:0] r;
        r = f;
        if (f[HOP_LSB +: HOP_W] != '0)
            r[HOP_LSB +: HOP_W] = f[HOP_LSB +: HOP_W] - HOP_W'(1);
        return r;
    endfunction

    always_comb begin
        in_v      = {pesi, ccwsi, cwsi};
        out_rdy   = {pero, ccwro, cwro};
        in_dat[0] = cwdi;
        in_dat[1] = ccwdi;
        in_dat[2] = pedi;
        for (int i = 0; i < 3; i++) begin
            full[i]   = (cnt_q[i] == (AW+1)'(DEPTH));
            head_v[i] = (cnt_q[i] != '0);
            push[i]   = in_v[i] && !full[i];
            ld[i]     = !out_v_q[i] || out_rdy[i];
        end
        head[0] = dec_hop(mem_q[0][rd_ptr_q[0]]);
        head[1] = dec_hop(mem_q[1][rd_ptr_q[1]]);
        head[2] = mem_q[2][rd_ptr_q[2]];

        for (int l = 0; l < 2; l++) begin
            fwd[l] = head_v[l] && (head[l][HOP_LSB +: HOP_W] != '0);
        end
        pe_req[0] = head_v[0] && !fwd[0];
        pe_req[1] = head_v[1] && !fwd[1];
        pe_req[2] = head_v[2] && (head[2][HOP_LSB +: HOP_W] == '0);
        pe_inj[0] = head_v[2] && !pe_req[2] && !head[2][DATA_W-2];
        pe_inj[1] = head_v[2] && !pe_req[2] &&  head[2][DATA_W-2];

        pop         = '0;
        out_v_d     = out_v_q;
        out_dat_d   = out_dat_q;
        link_prio_d = link_prio_q;
        pe_ptr_d    = pe_ptr_q;
        found       = 1'b0;
        idx         = 0;

        for (int l = 0; l < 2; l++) begin
            if (ld[l]) begin
                out_v_d[l] = 1'b0;
                if (fwd[l] && (!pe_inj[l] || !link_prio_q[l])) begin
                    out_v_d[l]     = 1'b1;
                    out_dat_d[l]   = head[l];
                    pop[l]         = 1'b1;
                    link_prio_d[l] = 1'b1;
                end else if (pe_inj[l]) begin
                    out_v_d[l]     = 1'b1;
                    out_dat_d[l]   = head[2];
                    pop[2]         = 1'b1;
                    link_prio_d[l] = 1'b0;
                end
            end
        end

        if (ld[2]) begin
            out_v_d[2] = 1'b0;
            for (int j = 0; j < 3; j++) begin
                idx = int'(pe_ptr_q) + j;
                if (idx > 2) idx = idx - 3;
                if (!found && pe_req[idx[1:0]]) begin
                    found          = 1'b1;
                    out_v_d[2]     = 1'b1;
                    out_dat_d[2]   = head[idx[1:0]];
                    pop[idx[1:0]]  = 1'b1;
                    pe_ptr_d       = (idx == 2) ? 2'd0 : 2'(idx + 1);
                end
            end
        end

        mem_d = mem_q;
        for (int i = 0; i < 3; i++) begin
            if (push[i]) mem_d[i][wr_ptr_q[i]] = in_dat[i];
            wr_ptr_d[i] = wr_ptr_q[i] + AW'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + AW'(pop[i]);
            cnt_d[i]    = cnt_q[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                for (int k = 0; k < DEPTH; k++) mem_q[i][k] <= '0;
                wr_ptr_q[i]  <= '0;
                rd_ptr_q[i]  <= '0;
                cnt_q[i]     <= '0;
                out_dat_q[i] <= '0;
            end
            out_v_q     <= '0;
            link_prio_q <= '0;
            pe_ptr_q    <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            out_dat_q   <= out_dat_d;
            out_v_q     <= out_v_d;
            link_prio_q <= link_prio_d;
            pe_ptr_q    <= pe_ptr_d;
        end
    end

    assign cwri  = !full[0];
    assign ccwri = !full[1];
    assign peri  = !full[2];
    assign cwso  = out_v_q[0];
    assign ccwso = out_v_q[1];
    assign peso  = out_v_q[2];
    assign cwdo  = out_dat_q[0];
    assign ccwdo = out_dat_q[1];
    assign pedo  = out_dat_q[2];

`ifdef RING_ROUTER_STATS_EN
    logic [15:0] eject_q, eject_d, stall_q, stall_d;

    always_comb begin
        eject_d = eject_q;
        stall_d = stall_q;
        if (out_v_q[2] && pero && (eject_q != 16'hFFFF)) eject_d = eject_q + 16'd1;
        if (|(out_v_q & ~out_rdy) && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            eject_q <= '0;
            stall_q <= '0;
        end else begin
            eject_q <= eject_d;
            stall_q <= stall_d;
        end
    end

    assign stat_eject = eject_q;
    assign stat_stall = stall_q;
`endif
endmodule

// File: doc/ring_router_bidir.md
RING_ROUTER_BIDIR -- requirements
Module: ring_router_bidir

Interface
REQ-001 Parameter DATA_W, 64, flit width; direction bit is [DATA_W-2] (0=CW, 1=CCW).
REQ-002 Parameter DEPTH, 2, entries per input FIFO; power of two, minimum 2.
REQ-003 Parameter HOP_LSB, 48, LSB of the hop-count field.
REQ-004 Parameter HOP_W, 8, hop-count field width.
REQ-005 Ports SHALL be exactly as below; one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 reset  in  1  asynchronous active-low reset.
REQ-008 cwsi  in  1  CW link input valid, from CCW-side neighbour.
REQ-009 cwri  out  1  CW link input ready.
REQ-010 cwdi  in  DATA_W  CW link input flit.
REQ-011 cwso  out  1  CW link output valid, to CW-side neighbour.
REQ-012 cwro  in  1  CW link output ready.
REQ-013 cwdo  out  DATA_W  CW link output flit.
REQ-014 ccwsi  in  1  CCW link input valid, from CW-side neighbour.
REQ-015 ccwri  out  1  CCW link input ready.
REQ-016 ccwdi  in  DATA_W  CCW link input flit.
REQ-017 ccwso  out  1  CCW link output valid.
REQ-018 ccwro  in  1  CCW link output ready.
REQ-019 ccwdo  out  DATA_W  CCW link output flit.
REQ-020 pesi  in  1  local PE injection valid.
REQ-021 peri  out  1  local PE injection ready.
REQ-022 pedi  in  DATA_W  local PE injection flit.
REQ-023 peso  out  1  local ejection valid.
REQ-024 pero  in  1  local ejection ready.
REQ-025 pedo  out  DATA_W  local ejection flit.

Function
REQ-026 Transfer on any channel occurs at a rising edge where valid and ready are both high; valid and data, once raised, are held until transfer.
REQ-027 Each input (cw, ccw, pe) feeds its own DEPTH-entry FIFO; cwri/ccwri/peri = FIFO not full, no same-cycle bypass when full.
REQ-028 Ring-input head: hop field decremented by 1 (hop==0 arriving is left at 0); if result is 0, route to PE output, else to the same-direction link output.
REQ-029 PE-input head: hop field unchanged; hop==0 routes to PE output (loopback), else to the link selected by the direction bit.
REQ-030 Each output is a single register stage, loaded when empty or transferring in the same cycle; full throughput of one flit/cycle/output.
REQ-031 Latency: input transfer at edge t, output valid after edge t+1 when uncontended.
REQ-032 Link-output arbitration: ring-forward vs PE-inject, round-robin, pointer flips after each grant; after reset ring-forward has priority.
REQ-033 PE-output arbitration: 3-way round-robin order cw, ccw, pe-loopback, pointer advances past the granted requester.
REQ-034 A head not granted, or whose target output is stalled, stays in its FIFO; no flit dropped, duplicated or reordered per input.
REQ-035 All flit bits other than the hop field pass unmodified.

Reset
REQ-036 reset low SHALL immediately empty all FIFOs, clear cwso/ccwso/peso to 0, reset arbiters to initial priority; in-flight flits are discarded, including mid-operation.
REQ-037 cwri/ccwri/peri SHALL read 1 one cycle after reset release; data outputs read 0 during reset.

Configuration
REQ-038 Macro RING_ROUTER_STATS_EN: when defined, adds outputs stat_eject (16 bit, counts PE-output transfers) and stat_stall (16 bit, counts cycles any output valid with ready low), both saturating at 0xFFFF, cleared by reset; when undefined, those ports and counters are absent and behaviour is otherwise identical.

Verification
REQ-039 Inject pedi=0x0001_0001_1111_2222 -> cwso with cwdo=same flit, hop unchanged, 2 cycles later.
REQ-040 Drive cwdi=0x0001_0001_1111_2222 -> peso with pedo=0x0000_0001_1111_2222; cwdi hop=3 -> cwdo hop=2.
REQ-041 Inject pedi=0x4000_0005_9999_AAAA (hop 0) -> loopback on pedo unchanged, no link output.
REQ-042 Hold cwro=0, stream CW forwards -> cwri falls after DEPTH+1 accepted flits, release -> all delivered in order.
REQ-043 Simultaneous CW forward and PE CW-inject every cycle -> cwdo alternates ring, PE, ring, PE.
REQ-044 Assert reset with full FIFOs -> all valids 0 at once, no stale flit delivered after release.
